// File: rtl/pc_seq_pkg.sv
// rtl/pc_seq_pkg.sv - shared state encoding and branch-select codes for pc_sequencer
package pc_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_ISSUE,
        ST_RESOLVE
    } state_t;

    localparam logic [2:0] BR_NEVER  = 3'd0;
    localparam logic [2:0] BR_ALWAYS = 3'd1;
    localparam logic [2:0] BR_SNEG   = 3'd2;
    localparam logic [2:0] BR_OP7    = 3'd3;
    localparam logic [2:0] BR_SPOS   = 3'd4;
    localparam logic [2:0] BR_RET    = 3'd5;
    localparam logic [2:0] BR_CALL   = 3'd6;
    localparam logic [2:0] BR_RSVD   = 3'd7;

endpackage

// File: rtl/branch_cond_sel.sv
// rtl/branch_cond_sel.sv - combinational take/target decode; return-stack ports exist only with PC_RAS_EN
module branch_cond_sel
    import pc_seq_pkg::*;
#(
    parameter int AW = 8
) (
    input  logic [2:0]    br_sel_i,
    input  logic          s_flag_i,
    input  logic          op_sign_i,
    input  logic [AW-1:0] br_target_i,
`ifdef PC_RAS_EN
    input  logic [AW-1:0] ras_top_i,
    input  logic          ras_empty_i,
    output logic          push_o,
    output logic          pop_o,
`endif
    output logic          take_o,
    output logic [AW-1:0] target_o
);

    always_comb begin
        take_o   = 1'b0;
        target_o = br_target_i;
`ifdef PC_RAS_EN
        push_o   = 1'b0;
        pop_o    = 1'b0;
`endif
        case (br_sel_i)
            BR_ALWAYS: take_o = 1'b1;
            BR_SNEG:   take_o = s_flag_i;
            BR_OP7:    take_o = op_sign_i;
            BR_SPOS:   take_o = ~s_flag_i;
`ifdef PC_RAS_EN
            BR_CALL: begin
                take_o = 1'b1;
                push_o = 1'b1;
            end
            // An empty-stack return falls through to PC+1; the caller flags the underflow.
            BR_RET: begin
                pop_o    = 1'b1;
                take_o   = ~ras_empty_i;
                target_o = ras_top_i;
            end
`else
            BR_CALL:   take_o = 1'b1;
`endif
            default:   take_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - fetch/issue/resolve program-counter controller; PC_RAS_EN adds a return stack
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int            AW        = 8,
    parameter int            IW        = 16,
    parameter logic [AW-1:0] RESET_PC  = '0,
    parameter int            RAS_DEPTH = 4
) (
    input  logic          CLK,
    input  logic          RST_N,
    output logic          IMEM_REQ,
    output logic [AW-1:0] IMEM_ADDR,
    input  logic          IMEM_ACK,
    input  logic [IW-1:0] IMEM_DATA,
    output logic          INSTR_VALID,
    output logic [IW-1:0] INSTR,
    input  logic          INSTR_READY,
    input  logic          BR_VALID,
    input  logic [2:0]    BR_SEL,
    input  logic [AW-1:0] BR_TARGET,
    input  logic          S_FLAG,
    input  logic [7:0]    OPERANDO1,
    output logic [2:0]    SEL_PC,
    output logic          ESCR_PC,
    output logic [AW-1:0] PC,
    output logic          RAS_ERR
);

    state_t        state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [IW-1:0] instr_q, instr_d;
    logic [2:0]    sel_q, sel_d;
    logic          escr_q, escr_d;
    logic          take;
    logic [AW-1:0] target;
    logic [AW-1:0] pc_inc;
    logic          resolve;
    logic [6:0]    unused_op;

    assign pc_inc    = pc_q + 1'b1;
    assign resolve   = (state_q == ST_RESOLVE) && BR_VALID;
    assign unused_op = OPERANDO1[6:0];

`ifdef PC_RAS_EN
    localparam int CW = $clog2(RAS_DEPTH + 1);

    logic [AW-1:0] ras_q [RAS_DEPTH];
    logic [CW-1:0] cnt_q;
    logic          err_q;
    logic          push, pop;

    branch_cond_sel #(.AW(AW)) u_cond (
        .br_sel_i    (BR_SEL),
        .s_flag_i    (S_FLAG),
        .op_sign_i   (OPERANDO1[7]),
        .br_target_i (BR_TARGET),
        .ras_top_i   (ras_q[0]),
        .ras_empty_i (cnt_q == '0),
        .push_o      (push),
        .pop_o       (pop),
        .take_o      (take),
        .target_o    (target)
    );

    // Entry 0 is the top; a push on a full stack shifts the oldest entry out.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < RAS_DEPTH; i++) ras_q[i] <= '0;
            cnt_q <= '0;
            err_q <= 1'b0;
        end else if (resolve && push) begin
            ras_q[0] <= pc_inc;
            for (int i = 1; i < RAS_DEPTH; i++) ras_q[i] <= ras_q[i-1];
            if (cnt_q == CW'(RAS_DEPTH)) err_q <= 1'b1;
            else                         cnt_q <= cnt_q + 1'b1;
        end else if (resolve && pop) begin
            if (cnt_q == '0) begin
                err_q <= 1'b1;
            end else begin
                for (int i = 0; i < RAS_DEPTH - 1; i++) ras_q[i] <= ras_q[i+1];
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

    assign RAS_ERR = err_q;
`else
    logic [31:0] unused_depth;
    assign unused_depth = RAS_DEPTH;

    branch_cond_sel #(.AW(AW)) u_cond (
        .br_sel_i    (BR_SEL),
        .s_flag_i    (S_FLAG),
        .op_sign_i   (OPERANDO1[7]),
        .br_target_i (BR_TARGET),
        .take_o      (take),
        .target_o    (target)
    );

    assign RAS_ERR = 1'b0;
`endif

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_PC;
            instr_q <= '0;
            sel_q   <= '0;
            escr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            sel_q   <= sel_d;
            escr_q  <= escr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        sel_d   = sel_q;
        escr_d  = 1'b0;
        case (state_q)
            ST_IDLE:  state_d = ST_FETCH;
            ST_FETCH: begin
                if (IMEM_ACK) begin
                    instr_d = IMEM_DATA;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (INSTR_READY) state_d = ST_RESOLVE;
            end
            ST_RESOLVE: begin
                if (BR_VALID) begin
                    pc_d    = take ? target : pc_inc;
                    sel_d   = BR_SEL;
                    escr_d  = take;
                    state_d = ST_FETCH;
                end
            end
            default:  state_d = ST_IDLE;
        endcase
    end

    assign IMEM_REQ    = (state_q == ST_FETCH);
    assign IMEM_ADDR   = pc_q;
    assign INSTR_VALID = (state_q == ST_ISSUE);
    assign INSTR       = instr_q;
    assign SEL_PC      = sel_q;
    assign ESCR_PC     = escr_q;
    assign PC          = pc_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - directed self-checking bench for pc_sequencer (PC_RAS_EN section when defined)
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_ack = 1'b0;
    logic [15:0] imem_data = '0;
    logic        instr_valid;
    logic [15:0] instr;
    logic        instr_ready = 1'b0;
    logic        br_valid = 1'b0;
    logic [2:0]  br_sel = '0;
    logic [7:0]  br_target = '0;
    logic        s_flag = 1'b0;
    logic [7:0]  operando1 = '0;
    logic [2:0]  sel_pc;
    logic        escr_pc;
    logic [7:0]  pc;
    logic        ras_err;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    pc_sequencer dut (
        .CLK         (clk),
        .RST_N       (rst_n),
        .IMEM_REQ    (imem_req),
        .IMEM_ADDR   (imem_addr),
        .IMEM_ACK    (imem_ack),
        .IMEM_DATA   (imem_data),
        .INSTR_VALID (instr_valid),
        .INSTR       (instr),
        .INSTR_READY (instr_ready),
        .BR_VALID    (br_valid),
        .BR_SEL      (br_sel),
        .BR_TARGET   (br_target),
        .S_FLAG      (s_flag),
        .OPERANDO1   (operando1),
        .SEL_PC      (sel_pc),
        .ESCR_PC     (escr_pc),
        .PC          (pc),
        .RAS_ERR     (ras_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Entered one tick after an edge with the DUT in FETCH; leaves it in FETCH of the next instruction.
    task automatic run_instr(input string tag, input int waits, input logic [15:0] data,
                             input logic [2:0] sel, input logic sf, input logic [7:0] op,
                             input logic [7:0] tgt, input logic [7:0] exp_pc, input logic exp_escr);
        logic [7:0] start_pc;
        start_pc = imem_addr;
        repeat (waits) step();
        chk({tag, ".req_wait"}, imem_req, 1);
        imem_ack  = 1'b1;
        imem_data = data;
        step();
        imem_ack  = 1'b0;
        chk({tag, ".req_drop"}, imem_req, 0);
        chk({tag, ".valid"}, instr_valid, 1);
        chk({tag, ".instr"}, instr, data);
        imem_ack  = 1'b1;
        imem_data = ~data;
        step();
        imem_ack  = 1'b0;
        chk({tag, ".hold"}, instr, data);
        instr_ready = 1'b1;
        step();
        instr_ready = 1'b0;
        chk({tag, ".valid_lo"}, instr_valid, 0);
        br_valid  = 1'b1;
        br_sel    = sel;
        s_flag    = sf;
        operando1 = op;
        br_target = tgt;
        step();
        br_valid  = 1'b0;
        s_flag    = ~sf;
        operando1 = ~op;
        chk({tag, ".pc"}, pc, exp_pc);
        chk({tag, ".addr"}, imem_addr, exp_pc);
        chk({tag, ".sel"}, sel_pc, sel);
        chk({tag, ".escr"}, escr_pc, exp_escr);
        chk({tag, ".refetch"}, imem_req, 1);
        step();
        chk({tag, ".escr_pulse"}, escr_pc, 0);
        chk({tag, ".pc_hold"}, pc, exp_pc);
        if (start_pc == exp_pc) chk({tag, ".moved"}, 0, 1);
    endtask

    initial begin
        #2;
        chk("rst.req", imem_req, 0);
        chk("rst.addr", imem_addr, 8'h00);
        chk("rst.valid", instr_valid, 0);
        chk("rst.instr", instr, 16'h0000);
        chk("rst.sel", sel_pc, 3'd0);
        chk("rst.escr", escr_pc, 0);
        chk("rst.ras_err", ras_err, 0);
        step();
        rst_n = 1'b1;
        chk("idle.req", imem_req, 0);
        step();
        chk("fetch.req", imem_req, 1);
        chk("fetch.addr", imem_addr, 8'h00);

        run_instr("seq0",   2, 16'hA001, 3'd0, 1'b0, 8'h00, 8'h55, 8'h01, 1'b0);
        run_instr("sflag1", 0, 16'hA002, 3'd2, 1'b1, 8'h00, 8'h40, 8'h40, 1'b1);
        run_instr("sflag0", 1, 16'hA003, 3'd2, 1'b0, 8'h00, 8'h80, 8'h41, 1'b0);
        run_instr("op7set", 0, 16'hA004, 3'd3, 1'b0, 8'h80, 8'h10, 8'h10, 1'b1);
        run_instr("op7clr", 0, 16'hA005, 3'd3, 1'b1, 8'h7F, 8'h90, 8'h11, 1'b0);
        run_instr("always", 0, 16'hA006, 3'd1, 1'b0, 8'h00, 8'hFF, 8'hFF, 1'b1);
        run_instr("wrap",   0, 16'hA007, 3'd0, 1'b1, 8'hFF, 8'h12, 8'h00, 1'b0);
        run_instr("nsflg0", 0, 16'hA008, 3'd4, 1'b0, 8'h00, 8'h33, 8'h33, 1'b1);
        run_instr("nsflg1", 0, 16'hA009, 3'd4, 1'b1, 8'h00, 8'h77, 8'h34, 1'b0);
        run_instr("rsvd",   0, 16'hA00A, 3'd7, 1'b1, 8'hFF, 8'h99, 8'h35, 1'b0);

`ifdef PC_RAS_EN
        run_instr("to05",   0, 16'hB000, 3'd1, 1'b0, 8'h00, 8'h05, 8'h05, 1'b1);
        run_instr("call",   0, 16'hB001, 3'd6, 1'b0, 8'h00, 8'h20, 8'h20, 1'b1);
        run_instr("ret",    0, 16'hB002, 3'd5, 1'b0, 8'h00, 8'hEE, 8'h06, 1'b1);
        chk("ret.ras_err", ras_err, 0);
        run_instr("ret_emp", 0, 16'hB003, 3'd5, 1'b0, 8'h00, 8'hEE, 8'h07, 1'b0);
        chk("ret_emp.ras_err", ras_err, 1);
        rst_n = 1'b0;
        #1;
        chk("ras.rst_err", ras_err, 0);
        step();
        rst_n = 1'b1;
        step();
        for (int i = 1; i <= 5; i++) begin
            run_instr($sformatf("call%0d", i), 0, 16'hC000, 3'd6, 1'b0, 8'h00,
                      8'(i * 16), 8'(i * 16), 1'b1);
            chk($sformatf("call%0d.ras_err", i), ras_err, (i == 5) ? 1 : 0);
        end
        for (int i = 4; i >= 1; i--) begin
            run_instr($sformatf("pop%0d", i), 0, 16'hC100, 3'd5, 1'b0, 8'h00,
                      8'hEE, 8'(i * 16 + 1), 1'b1);
        end
        run_instr("pop_emp", 0, 16'hC200, 3'd5, 1'b0, 8'h00, 8'hEE, 8'h12, 1'b0);
`else
        run_instr("call",   0, 16'hB001, 3'd6, 1'b0, 8'h00, 8'h20, 8'h20, 1'b1);
        run_instr("ret",    0, 16'hB002, 3'd5, 1'b1, 8'hFF, 8'hEE, 8'h21, 1'b0);
        chk("ret.ras_err", ras_err, 0);
`endif

        chk("arst_pre.req", imem_req, 1);
        rst_n = 1'b0;
        #1;
        chk("arst_fetch.req", imem_req, 0);
        chk("arst_fetch.pc", pc, 8'h00);
        step();
        rst_n = 1'b1;
        step();
        chk("restart.req", imem_req, 1);
        chk("restart.addr", imem_addr, 8'h00);
        imem_ack  = 1'b1;
        imem_data = 16'h5A5A;
        step();
        imem_ack  = 1'b0;
        chk("arst_pre.valid", instr_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("arst_issue.valid", instr_valid, 0);
        chk("arst_issue.instr", instr, 16'h0000);
        step();
        rst_n = 1'b1;
        step();
        chk("restart2.req", imem_req, 1);
        run_instr("post", 0, 16'hD001, 3'd0, 1'b0, 8'h00, 8'h44, 8'h01, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
